obc_da_accumulator: RTL
=======================

// Module: obc_da_accumulator
// PURPOSE
//  Sequential shift-accumulate back end of the OBC distributed-arithmetic DFT datapath.
//  - Each ACCUM cycle it requests one input bit-slice (MSB first) from the slice sequencer.
//  - It consumes the eight 32-bit partial words that the OBC coefficient ROMs return for that slice.
//  - It sums them and shift-accumulates into an exact integer.
//  - It adds the per-output OBC offset constant.
//  - It presents one DFT output component with a valid/ready handshake.
// PARAMETERS
//  N_BITS  16  input sample width = number of bit-slices per output
//  COEF_W  32  width of each ROM word (two's complement)
//  N_TERMS 8   ROM words summed per slice
//  RES_W   COEF_W+3+N_BITS (51)  result width; 3 guard bits cover the 8-term sum
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               asynchronous active-low reset
//  start        in   1               request one conversion; accepted when start & start_ready
//  start_ready  out  1               high in IDLE, or in DONE while out_ready=1
//  offset_in    in   RES_W           OBC offset term, sampled on start acceptance
//  slice_valid  out  1               high during ACCUM; slice_idx is meaningful
//  slice_idx    out  $clog2(N_BITS)  bit-slice requested this cycle, N_BITS-1 down to 0
//  rom_data     in   N_TERMS*COEF_W  ROM words for slice_idx, same cycle; word j = bits [j*COEF_W +: COEF_W]
//  out_valid    out  1               result valid, held until out_ready
//  out_ready    in   1               downstream accepts the result
//  result       out  RES_W           signed output component
// BEHAVIOUR
//  Reset values
//  - rst_n=0 at any time, including mid-conversion, clears immediately:
//    state=IDLE, acc=0, offset reg=0, slice_idx=0, slice_valid=0, out_valid=0, result=0.
//  FSM: IDLE -> ACCUM -> DONE
//  - IDLE: start=1 latches offset_in, sets slice_idx=N_BITS-1, goes to ACCUM.
//  - ACCUM: lasts exactly N_BITS cycles; slice_idx decrements by 1 each cycle.
//    - Leaves for DONE after the cycle with slice_idx=0.
//  - DONE: out_valid=1; result and out_valid are stable while out_ready=0.
//    - out_ready=1 and start=0 -> IDLE.
//    - out_ready=1 and start=1 -> ACCUM directly; the new offset is latched; no bubble.
//  - start is ignored in ACCUM and in DONE while out_ready=0. No error flag.
//  Arithmetic
//  - S = sign-extended sum of the N_TERMS words, COEF_W+3 bits; never overflows.
//  - First ACCUM cycle (slice N_BITS-1): acc = -S.
//  - Later ACCUM cycles: acc = (acc <<< 1) + S.
//  - Entering DONE: result = acc + offset.
//  - Exact integer result = -S[N-1]*2^(N-1) + sum over k<N-1 of S[k]*2^k + offset.
//  - RES_W is sized so nothing saturates, truncates or wraps.
//  Timing
//  - start accepted at edge T -> slices during cycles T+1..T+N_BITS -> out_valid high from T+N_BITS+1.
//  - Throughput: one result per N_BITS+1 cycles under continuous start and out_ready.
//  - rom_data must be valid in the same cycle as slice_idx (combinational ROM path).
//    A registered ROM needs a one-cycle-latency variant; that variant is out of scope.
// STRUCTURE
//  Shared package obc_dft_pkg
//  - N_BITS, COEF_W, N_TERMS and RES_W defaults.
//  - State enum {IDLE, ACCUM, DONE}.
//  - Function sext_sum returning the guard-bit width.
//  Sub-module obc_slice_sum
//  - Combinational 8-input sign-extending adder tree, COEF_W -> COEF_W+3.
//  - Separated so it can be pipelined later.
//  Top level: FSM, slice counter, accumulator, offset register and output register.
// TESTING
//  1. All words =32'd1 every slice, offset=0 -> S=8 -> result=-8 (51-bit two's complement); out_valid at T+17.
//  2. Only word0=1 and only on slice 15, offset=100 -> result=-32668.
//  3. All words =32'hFFFFFFFF every slice, offset=0 -> S=-8 -> result=+8.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> result and out_valid stable, start_ready=0.
//     Then out_ready=1 with start=1 -> next conversion starts without a bubble.
//  5. rst_n low for 1 cycle while slice_idx=9 -> out_valid=0, slice_valid=0, start_ready=1.
//     Next conversion gives the correct result for its own data.
//  6. 4 back-to-back conversions with random ROM data -> results match the formula;
//     each start-to-out_valid spacing is 17 cycles.

Source files
------------

// File: rtl/obc_dft_pkg.sv
// Shared constants, FSM state type and the sign-extending slice-sum helper
// for the OBC distributed-arithmetic DFT datapath.
package obc_dft_pkg;

  localparam int N_BITS  = 16;
  localparam int COEF_W  = 32;
  localparam int N_TERMS = 8;
  localparam int GUARD_W = 3;
  localparam int SUM_W   = COEF_W + GUARD_W;
  localparam int RES_W   = SUM_W + N_BITS;
  localparam int IDX_W   = $clog2(N_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Adds the N_TERMS two's-complement ROM words after widening each by the guard bits.
  function automatic logic signed [SUM_W-1:0] sext_sum(input logic [N_TERMS*COEF_W-1:0] words);
    logic signed [SUM_W-1:0] total;
    logic        [COEF_W-1:0] word;
    total = '0;
    for (int j = 0; j < N_TERMS; j++) begin
      word  = words[j*COEF_W +: COEF_W];
      total = total + $signed({{GUARD_W{word[COEF_W-1]}}, word});
    end
    return total;
  endfunction

endpackage

// File: rtl/obc_slice_sum.sv
// Combinational sign-extending adder tree over the eight ROM words of one
// bit-slice; kept apart so a pipeline stage can be inserted later.
module obc_slice_sum
  import obc_dft_pkg::*;
(
  input  logic [N_TERMS*COEF_W-1:0] rom_data,
  output logic signed [SUM_W-1:0]   sum
);

  // Slice sum with guard bits; cannot overflow for eight terms.
  always_comb begin
    sum = sext_sum(rom_data);
  end

endmodule

// File: rtl/obc_da_accumulator.sv
// Shift-accumulate back end: walks the input bit-slices MSB first, accumulates
// the per-slice ROM sums, adds the OBC offset and hands out one result.
module obc_da_accumulator
  import obc_dft_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      start_ready,
  input  logic [RES_W-1:0]          offset_in,
  output logic                      slice_valid,
  output logic [IDX_W-1:0]          slice_idx,
  input  logic [N_TERMS*COEF_W-1:0] rom_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          result
);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic signed [SUM_W-1:0] slice_sum_s;
  logic signed [RES_W-1:0] sum_ext_s;
  logic signed [RES_W-1:0] acc_nxt_s;
  logic signed [RES_W-1:0] acc_r;
  logic signed [RES_W-1:0] offset_r;
  logic        [RES_W-1:0] result_r;
  logic        [IDX_W-1:0] idx_r;
  logic                    slice_valid_r;
  logic                    out_valid_r;
  logic                    start_ready_s;
  logic                    accept_s;
  logic                    last_slice_s;

  obc_slice_sum u_slice_sum (
    .rom_data (rom_data),
    .sum      (slice_sum_s)
  );

  assign start_ready = start_ready_s;
  assign slice_valid = slice_valid_r;
  assign slice_idx   = idx_r;
  assign out_valid   = out_valid_r;
  assign result      = result_r;

  // Start acceptance: free in IDLE, or in DONE when the result leaves this cycle.
  always_comb begin
    start_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: start_ready_s = 1'b1;
      ST_DONE: start_ready_s = out_ready;
      default: start_ready_s = 1'b0;
    endcase
    accept_s     = start & start_ready_s;
    last_slice_s = (idx_r == IDX_W'(0));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_ACCUM;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_slice_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_ACCUM;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (start) state_nxt_s = ST_ACCUM;
          else       state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // The MSB slice carries negative weight, so it seeds the accumulator negated.
  always_comb begin
    sum_ext_s = $signed({{N_BITS{slice_sum_s[SUM_W-1]}}, slice_sum_s});
    if (idx_r == LAST_IDX) acc_nxt_s = -sum_ext_s;
    else                   acc_nxt_s = (acc_r <<< 1) + sum_ext_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Slice counter, accumulator, offset and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r         <= '0;
      offset_r      <= '0;
      result_r      <= '0;
      idx_r         <= IDX_W'(0);
      slice_valid_r <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            offset_r      <= offset_in;
            idx_r         <= LAST_IDX;
            slice_valid_r <= 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_nxt_s;
          if (last_slice_s) begin
            result_r      <= acc_nxt_s + offset_r;
            out_valid_r   <= 1'b1;
            slice_valid_r <= 1'b0;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (start) begin
              offset_r      <= offset_in;
              idx_r         <= LAST_IDX;
              slice_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          slice_valid_r <= 1'b0;
          out_valid_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
